// File: rtl/branch_pkg.sv
// Shared types for branch resolution and fetch redirect sequencing.
// Holds the redirect FSM state encoding and the target-source selector constants.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } redir_state_t;

  localparam logic TGT_PC_REL = 1'b0;
  localparam logic TGT_REG    = 1'b1;

endpackage

// File: rtl/bta_generator.sv
// PC-relative branch target: pc + 4 + sext(offset) << 2, modulo 2^32.
// Purely combinational, zero latency; no flow control.
module bta_generator (
  input  logic [31:0] pc,
  input  logic [15:0] offset,
  output logic [31:0] bta
);

  logic [31:0] offset_ext;

  assign offset_ext = {{14{offset[15]}}, offset, 2'b00};
  assign bta        = pc + 32'd4 + offset_ext;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch sequencing: latches a taken target, waits for the delay slot, redirects IF.
// Redirect appears one cycle after the delay slot is seen; held under valid/ready, EX stalled meanwhile.
module branch_redirect_ctrl
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic        ex_tgt_sel,
  input  logic [31:0] ex_pc,
  input  logic [15:0] ex_offset,
  input  logic [31:0] ex_reg_tgt,
  input  logic        ds_fetched,
  input  logic        exc_flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        redir_misalign,
  input  logic        redir_ready,
  output logic        ex_stall,
  output logic [31:0] branch_cnt,
  output logic [31:0] taken_cnt
);

  redir_state_t state_q, state_d;
  logic [31:0]  tgt_q;
  logic [31:0]  bta;
  logic [31:0]  tgt_mux;
  logic [31:0]  branch_cnt_q;
  logic [31:0]  taken_cnt_q;
  logic         accept;

  bta_generator u_bta (
    .pc     (ex_pc),
    .offset (ex_offset),
    .bta    (bta)
  );

  assign tgt_mux = (ex_tgt_sel == TGT_REG) ? ex_reg_tgt : bta;

  // Flush masks acceptance so a branch squashed by an exception is never counted.
  assign accept = (state_q == IDLE) & ex_valid & ex_is_branch & ~exc_flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && ex_taken) begin
          state_d = ds_fetched ? REDIRECT : WAIT_DS;
        end
      end
      WAIT_DS: begin
        if (ds_fetched) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redir_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (exc_flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (exc_flush) begin
        tgt_q <= '0;
      end else if (accept && ex_taken) begin
        tgt_q <= tgt_mux;
      end
      if (accept) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
        if (ex_taken) begin
          taken_cnt_q <= taken_cnt_q + 32'd1;
        end
      end
    end
  end

  assign redir_valid    = (state_q == REDIRECT);
  assign redir_pc       = tgt_q;
  assign redir_misalign = redir_valid & (tgt_q[1:0] != 2'b00);
  assign ex_stall       = (state_q != IDLE);
  assign branch_cnt     = branch_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule
